// File: rtl/sd_host_std_regs.sv
// SD host standard register set: word-addressed CPU register map, command issue/response
// capture, one data FIFO per direction and a masked interrupt status block.
module sd_host_std_regs #(
    parameter int          ADDR_W     = 8,
    parameter int          FIFO_DEPTH = 16,
    parameter int          NUM_INT    = 16,
    parameter logic [31:0] CAPS       = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               bus_valid,
    input  logic               bus_write,
    input  logic [ADDR_W-1:0]  bus_addr,
    input  logic [31:0]        bus_wdata,
    input  logic [3:0]         bus_be,
    output logic [31:0]        bus_rdata,
    output logic               bus_rvalid,
    output logic               cmd_issue,
    output logic [31:0]        cmd_arg,
    output logic [15:0]        cmd_word,
    input  logic               rsp_valid,
    input  logic [127:0]       rsp_data,
    input  logic               rd_push,
    input  logic [31:0]        rd_data,
    output logic               rd_full,
    input  logic               wr_pop,
    output logic [31:0]        wr_data,
    output logic               wr_empty,
    input  logic [NUM_INT-1:0] int_set,
    output logic               irq
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LVL_W = AW + 1;
    localparam logic [AW:0]    PTR_ONE   = 1;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    localparam logic [ADDR_W-1:0] A_ARG     = ADDR_W'(8'h00);
    localparam logic [ADDR_W-1:0] A_BLK     = ADDR_W'(8'h04);
    localparam logic [ADDR_W-1:0] A_CMD     = ADDR_W'(8'h0C);
    localparam logic [ADDR_W-1:0] A_RSP0    = ADDR_W'(8'h10);
    localparam logic [ADDR_W-1:0] A_RSP1    = ADDR_W'(8'h14);
    localparam logic [ADDR_W-1:0] A_RSP2    = ADDR_W'(8'h18);
    localparam logic [ADDR_W-1:0] A_RSP3    = ADDR_W'(8'h1C);
    localparam logic [ADDR_W-1:0] A_BUF     = ADDR_W'(8'h20);
    localparam logic [ADDR_W-1:0] A_PRESENT = ADDR_W'(8'h24);
    localparam logic [ADDR_W-1:0] A_HOST    = ADDR_W'(8'h28);
    localparam logic [ADDR_W-1:0] A_INT_ST  = ADDR_W'(8'h30);
    localparam logic [ADDR_W-1:0] A_INT_EN  = ADDR_W'(8'h34);
    localparam logic [ADDR_W-1:0] A_CAPS    = ADDR_W'(8'h40);

    // Bus handshake: a request is taken on every rising edge where bus_valid=1 (no back-pressure);
    // reads answer with bus_rvalid=1 and bus_rdata exactly one cycle later.
    logic [ADDR_W-1:0] word_addr;
    logic              wr_en, rd_en;
    logic [31:0]       be_mask;
    logic              unused_ok;

    assign word_addr = {bus_addr[ADDR_W-1:2], 2'b00};
    assign wr_en     = bus_valid & bus_write;
    assign rd_en     = bus_valid & ~bus_write;
    assign be_mask   = {{8{bus_be[3]}}, {8{bus_be[2]}}, {8{bus_be[1]}}, {8{bus_be[0]}}};
    assign unused_ok = ^bus_addr[1:0];

    logic [31:0]        arg_q, blk_q, cmd_q, host_ctl_q;
    logic [31:0]        rsp_q [4];
    logic               inhibit;
    logic [NUM_INT-1:0] int_status, int_en;

    // Read FIFO: card data toward the CPU
    logic [31:0]      rd_mem [FIFO_DEPTH];
    logic [AW:0]      rd_wptr, rd_rptr;
    logic [LVL_W-1:0] rd_level;
    logic             rd_empty, rd_pop_req, rd_pop_ok, rd_push_ok;

    assign rd_level   = rd_wptr - rd_rptr;
    assign rd_empty   = (rd_wptr == rd_rptr);
    assign rd_full    = (rd_level == LVL_FULL);
    assign rd_pop_req = rd_en & (word_addr == A_BUF);
    assign rd_pop_ok  = rd_pop_req & ~rd_empty;
    assign rd_push_ok = rd_push & (~rd_full | rd_pop_ok);

    // Write FIFO: CPU data toward the card
    logic [31:0]      wf_mem [FIFO_DEPTH];
    logic [AW:0]      wf_wptr, wf_rptr;
    logic [LVL_W-1:0] wf_level;
    logic             wf_full, wf_push_req, wf_push_ok, wf_pop_ok;

    assign wf_level    = wf_wptr - wf_rptr;
    assign wr_empty    = (wf_wptr == wf_rptr);
    assign wf_full     = (wf_level == LVL_FULL);
    assign wf_pop_ok   = wr_pop & ~wr_empty;
    assign wf_push_req = wr_en & (word_addr == A_BUF);
    assign wf_push_ok  = wf_push_req & (~wf_full | wf_pop_ok);
    assign wr_data     = wr_empty ? 32'h0 : wf_mem[wf_rptr[AW-1:0]];

    // A response arriving in the same cycle frees the command slot for a coincident CMD write.
    logic cmd_acc, cmd_go;
    assign cmd_acc  = wr_en & (word_addr == A_CMD) & ~(inhibit & ~rsp_valid);
    assign cmd_go   = cmd_acc & bus_be[1];
    assign cmd_arg  = arg_q;
    assign cmd_word = cmd_q[15:0];

    logic [15:0]        ev16;
    logic [NUM_INT-1:0] int_ev, int_clr, int_status_nxt;

    assign ev16           = {(rd_pop_req & rd_empty) | (wf_push_req & ~wf_push_ok), 14'b0, rsp_valid};
    assign int_ev         = int_set | ev16[NUM_INT-1:0];
    assign int_clr        = (wr_en && word_addr == A_INT_ST) ? bus_wdata[NUM_INT-1:0] : '0;
    assign int_status_nxt = (int_status & ~int_clr) | int_ev;

    logic [31:0] present, rdata_nxt;

    always_comb begin
        present                 = '0;
        present[0]              = inhibit;
        present[8]              = ~wf_full;
        present[11]             = ~rd_empty;
        present[16 +: LVL_W]    = rd_level;
    end

    always_comb begin
        rdata_nxt = '0;
        case (word_addr)
            A_ARG:     rdata_nxt = arg_q;
            A_BLK:     rdata_nxt = blk_q;
            A_CMD:     rdata_nxt = cmd_q;
            A_RSP0:    rdata_nxt = rsp_q[0];
            A_RSP1:    rdata_nxt = rsp_q[1];
            A_RSP2:    rdata_nxt = rsp_q[2];
            A_RSP3:    rdata_nxt = rsp_q[3];
            A_BUF:     rdata_nxt = rd_empty ? 32'h0 : rd_mem[rd_rptr[AW-1:0]];
            A_PRESENT: rdata_nxt = present;
            A_HOST:    rdata_nxt = host_ctl_q;
            A_INT_ST:  rdata_nxt[NUM_INT-1:0] = int_status;
            A_INT_EN:  rdata_nxt[NUM_INT-1:0] = int_en;
            A_CAPS:    rdata_nxt = CAPS;
            default:   rdata_nxt = '0;
        endcase
    end

    // FIFO storage is not reset; clearing the pointers discards the contents.
    always_ff @(posedge clk) begin
        if (rd_push_ok) rd_mem[rd_wptr[AW-1:0]] <= rd_data;
        if (wf_push_ok) wf_mem[wf_wptr[AW-1:0]] <= bus_wdata;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            arg_q      <= '0;
            blk_q      <= '0;
            cmd_q      <= '0;
            host_ctl_q <= '0;
            for (int i = 0; i < 4; i++) rsp_q[i] <= '0;
            inhibit    <= 1'b0;
            int_status <= '0;
            int_en     <= '0;
            irq        <= 1'b0;
            cmd_issue  <= 1'b0;
            bus_rvalid <= 1'b0;
            bus_rdata  <= '0;
            rd_wptr    <= '0;
            rd_rptr    <= '0;
            wf_wptr    <= '0;
            wf_rptr    <= '0;
        end else begin
            if (wr_en) begin
                case (word_addr)
                    A_ARG:    arg_q      <= (arg_q & ~be_mask) | (bus_wdata & be_mask);
                    A_BLK:    blk_q      <= (blk_q & ~be_mask) | (bus_wdata & be_mask);
                    A_HOST:   host_ctl_q <= (host_ctl_q & ~be_mask) | (bus_wdata & be_mask);
                    A_INT_EN: int_en     <= (int_en & ~be_mask[NUM_INT-1:0])
                                            | (bus_wdata[NUM_INT-1:0] & be_mask[NUM_INT-1:0]);
                    default: ;
                endcase
            end
            if (cmd_acc) cmd_q <= (cmd_q & ~be_mask) | (bus_wdata & be_mask);
            cmd_issue <= cmd_go;
            if (cmd_go)         inhibit <= 1'b1;
            else if (rsp_valid) inhibit <= 1'b0;
            if (rsp_valid) begin
                for (int i = 0; i < 4; i++) rsp_q[i] <= rsp_data[32*i +: 32];
            end
            int_status <= int_status_nxt;
            irq        <= |(int_status & int_en);
            bus_rvalid <= rd_en;
            if (rd_en) bus_rdata <= rdata_nxt;
            if (rd_push_ok) rd_wptr <= rd_wptr + PTR_ONE;
            if (rd_pop_ok)  rd_rptr <= rd_rptr + PTR_ONE;
            if (wf_push_ok) wf_wptr <= wf_wptr + PTR_ONE;
            if (wf_pop_ok)  wf_rptr <= wf_rptr + PTR_ONE;
        end
    end

endmodule

// File: tb/tb_sd_host_std_regs.sv
// Directed-plus-random bench for sd_host_std_regs; expectations come from queue/array models.
module tb_sd_host_std_regs;

    localparam logic [31:0] CAPS_V = 32'hC0DE_0042;

    logic         clk, resetn;
    logic         bus_valid, bus_write;
    logic [7:0]   bus_addr;
    logic [31:0]  bus_wdata;
    logic [3:0]   bus_be;
    logic [31:0]  bus_rdata;
    logic         bus_rvalid, cmd_issue;
    logic [31:0]  cmd_arg;
    logic [15:0]  cmd_word;
    logic         rsp_valid;
    logic [127:0] rsp_data;
    logic         rd_push, rd_full, wr_pop, wr_empty, irq;
    logic [31:0]  rd_data, wr_data;
    logic [15:0]  int_set;

    sd_host_std_regs #(.ADDR_W(8), .FIFO_DEPTH(16), .NUM_INT(16), .CAPS(CAPS_V)) dut (
        .clk(clk), .resetn(resetn),
        .bus_valid(bus_valid), .bus_write(bus_write), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid),
        .cmd_issue(cmd_issue), .cmd_arg(cmd_arg), .cmd_word(cmd_word),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rd_push(rd_push), .rd_data(rd_data), .rd_full(rd_full),
        .wr_pop(wr_pop), .wr_data(wr_data), .wr_empty(wr_empty),
        .int_set(int_set), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] rd_q[$];
    logic [31:0] wr_q[$];
    logic [15:0] m_status, m_en, m_cmd;
    logic        m_inhibit;
    logic [31:0] m_arg;
    logic [31:0] m_rsp [4];

    function automatic logic [31:0] m_present();
        logic [31:0] p;
        p = m_inhibit ? 32'h1 : 32'h0;
        if (wr_q.size() < 16) p = p + 32'h100;
        if (rd_q.size() > 0)  p = p + 32'h800;
        p = p + (32'(rd_q.size()) << 16);
        return p;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        bus_valid = 1'b1; bus_write = 1'b1; bus_addr = a; bus_wdata = d; bus_be = be;
        tick(1);
        bus_valid = 1'b0; bus_write = 1'b0; bus_be = 4'h0;
    endtask

    task automatic bus_rd(input logic [7:0] a, output logic [31:0] d);
        bus_valid = 1'b1; bus_write = 1'b0; bus_addr = a;
        tick(1);
        bus_valid = 1'b0;
        check("rvalid", 32'(bus_rvalid), 32'h1);
        d = bus_rdata;
    endtask

    task automatic read_check(input string tag, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_rd(a, d);
        check(tag, d, exp);
    endtask

    task automatic send_rsp();
        logic [31:0] w [4];
        for (int k = 0; k < 4; k++) begin
            w[k] = $urandom;
            m_rsp[k] = w[k];
        end
        rsp_data  = {w[3], w[2], w[1], w[0]};
        rsp_valid = 1'b1;
    endtask

    task automatic model_reset();
        rd_q.delete(); wr_q.delete();
        m_status = '0; m_en = '0; m_cmd = '0; m_inhibit = 1'b0; m_arg = '0;
        for (int k = 0; k < 4; k++) m_rsp[k] = '0;
    endtask

    initial begin
        logic [31:0] d, exp_v, v;
        logic [15:0] s, c;

        bus_valid = 0; bus_write = 0; bus_addr = 0; bus_wdata = 0; bus_be = 0;
        rsp_valid = 0; rsp_data = '0; rd_push = 0; rd_data = 0; wr_pop = 0; int_set = 0;
        resetn = 1'b0;
        model_reset();
        tick(2);

        // Reset state
        check("rst_rdata", bus_rdata, 32'h0);
        check("rst_rvalid", 32'(bus_rvalid), 32'h0);
        check("rst_issue", 32'(cmd_issue), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_rd_full", 32'(rd_full), 32'h0);
        check("rst_wr_empty", 32'(wr_empty), 32'h1);
        check("rst_wr_data", wr_data, 32'h0);
        check("rst_cmd_word", 32'(cmd_word), 32'h0);
        resetn = 1'b1;
        tick(1);

        read_check("present_rst", 8'h24, 32'h0000_0100);
        tick(1);
        check("rvalid_drop", 32'(bus_rvalid), 32'h0);
        read_check("caps", 8'h40, CAPS_V);
        bus_wr(8'h08, 32'hFFFF_FFFF, 4'hF);
        check("no_rvalid_on_write", 32'(bus_rvalid), 32'h0);
        read_check("unmapped", 8'h08, 32'h0);

        // Command issue / inhibit
        bus_wr(8'h00, 32'h1234_5678, 4'hF); m_arg = 32'h1234_5678;
        bus_wr(8'h0C, 32'h0000_1100, 4'hF); m_cmd = 16'h1100; m_inhibit = 1'b1;
        check("issue_pulse", 32'(cmd_issue), 32'h1);
        check("cmd_arg", cmd_arg, m_arg);
        check("cmd_word", 32'(cmd_word), 32'(m_cmd));
        tick(1);
        check("issue_one_cycle", 32'(cmd_issue), 32'h0);
        read_check("present_inhibit", 8'h24, m_present());
        bus_wr(8'h0C, 32'h0000_2200, 4'hF);
        check("inhibit_no_pulse", 32'(cmd_issue), 32'h0);
        tick(1);
        check("inhibit_no_pulse2", 32'(cmd_issue), 32'h0);
        read_check("cmd_kept", 8'h0C, 32'(m_cmd));

        send_rsp();
        tick(1);
        rsp_valid = 1'b0; m_inhibit = 1'b0; m_status[0] = 1'b1;
        for (int k = 0; k < 4; k++) read_check("rsp_readback", 8'(8'h10 + 4 * k), m_rsp[k]);
        read_check("present_after_rsp", 8'h24, m_present());
        read_check("int_rsp_bit", 8'h30, 32'(m_status));
        bus_wr(8'h30, 32'h1, 4'hF); m_status[0] = 1'b0;
        read_check("int_w1c", 8'h30, 32'(m_status));

        // Partial CMD write without byte 1: updates the low byte, launches nothing
        bus_wr(8'h0C, 32'h0000_ABCD, 4'b0001); m_cmd[7:0] = 8'hCD;
        check("be0_no_issue", 32'(cmd_issue), 32'h0);
        check("be0_cmd_word", 32'(cmd_word), 32'(m_cmd));

        // Random commands; the last one is left outstanding
        for (int i = 0; i < 4; i++) begin
            v = $urandom; c = 16'($urandom_range(0, 16'hFFFF));
            bus_wr(8'h00, v, 4'hF); m_arg = v;
            bus_wr(8'h0C, 32'(c), 4'b0011); m_cmd = c; m_inhibit = 1'b1;
            check("rnd_issue", 32'(cmd_issue), 32'h1);
            check("rnd_cmd_word", 32'(cmd_word), 32'(m_cmd));
            check("rnd_cmd_arg", cmd_arg, m_arg);
            if (i < 3) begin
                send_rsp();
                tick(1);
                rsp_valid = 1'b0; m_inhibit = 1'b0; m_status[0] = 1'b1;
                read_check("rnd_rsp", 8'(8'h10 + 4 * (i % 4)), m_rsp[i % 4]);
            end
        end
        // Response and new command on the same edge: the new command wins the slot
        send_rsp();
        bus_wr(8'h0C, 32'h0000_3300, 4'hF);
        rsp_valid = 1'b0; m_cmd = 16'h3300; m_inhibit = 1'b1; m_status[0] = 1'b1;
        check("coincident_issue", 32'(cmd_issue), 32'h1);
        check("coincident_word", 32'(cmd_word), 32'(m_cmd));
        read_check("coincident_present", 8'h24, m_present());
        send_rsp();
        tick(1);
        rsp_valid = 1'b0; m_inhibit = 1'b0;
        read_check("rsp3_final", 8'h1C, m_rsp[3]);
        read_check("int_after_cmds", 8'h30, 32'(m_status));
        bus_wr(8'h30, 32'hFFFF, 4'hF); m_status = '0;

        // Read FIFO fill, full push+pop, drain past empty
        for (int i = 0; i < 16; i++) begin
            rd_push = 1'b1; rd_data = $urandom; rd_q.push_back(rd_data);
            tick(1);
        end
        rd_push = 1'b0;
        check("rd_full", 32'(rd_full), 32'h1);
        read_check("present_rd_full", 8'h24, m_present());
        rd_push = 1'b1; rd_data = $urandom;
        bus_valid = 1'b1; bus_write = 1'b0; bus_addr = 8'h20;
        tick(1);
        bus_valid = 1'b0; rd_push = 1'b0;
        exp_v = rd_q.pop_front(); rd_q.push_back(rd_data);
        check("full_pushpop_data", bus_rdata, exp_v);
        check("full_pushpop_full", 32'(rd_full), 32'h1);
        for (int i = 0; i < 17; i++) begin
            if (rd_q.size() > 0) exp_v = rd_q.pop_front();
            else begin
                exp_v = 32'h0; m_status[15] = 1'b1;
            end
            read_check("rd_fifo_data", 8'h20, exp_v);
        end
        check("rd_not_full", 32'(rd_full), 32'h0);
        read_check("underflow_int", 8'h30, 32'(m_status));
        bus_wr(8'h30, 32'h8000, 4'hF); m_status[15] = 1'b0;

        // Write FIFO fill past full, then drain
        for (int i = 0; i < 17; i++) begin
            v = $urandom;
            if (wr_q.size() < 16) wr_q.push_back(v);
            else m_status[15] = 1'b1;
            bus_wr(8'h20, v, 4'h0);
        end
        read_check("present_wr_full", 8'h24, m_present());
        read_check("overflow_int", 8'h30, 32'(m_status));
        check("wr_not_empty", 32'(wr_empty), 32'h0);
        for (int i = 0; i < 16; i++) begin
            check("wr_fifo_data", wr_data, wr_q.pop_front());
            wr_pop = 1'b1;
            tick(1);
            wr_pop = 1'b0;
        end
        check("wr_empty", 32'(wr_empty), 32'h1);
        read_check("present_wr_empty", 8'h24, m_present());
        bus_wr(8'h30, 32'h8000, 4'hF); m_status[15] = 1'b0;

        // Interrupts
        bus_wr(8'h34, 32'h0002, 4'hF); m_en = 16'h0002;
        int_set = 16'h0002;
        tick(1);
        int_set = '0; m_status[1] = 1'b1;
        check("irq_lag", 32'(irq), 32'h0);
        tick(1);
        check("irq_set", 32'(irq), 32'h1);
        int_set = 16'h0002;
        bus_wr(8'h30, 32'h0002, 4'hF);
        int_set = '0;
        read_check("set_beats_clear", 8'h30, 32'(m_status));
        bus_wr(8'h30, 32'h0002, 4'hF); m_status[1] = 1'b0;
        check("irq_lag_clear", 32'(irq), 32'h1);
        tick(1);
        check("irq_cleared", 32'(irq), 32'h0);
        for (int i = 0; i < 6; i++) begin
            m_en = 16'($urandom);
            s = 16'($urandom & $urandom);
            bus_wr(8'h34, 32'(m_en), 4'hF);
            int_set = s;
            tick(1);
            int_set = '0; m_status = m_status | s;
            tick(1);
            check("rnd_irq", 32'(irq), ((m_status & m_en) != 0) ? 32'h1 : 32'h0);
            read_check("rnd_int_status", 8'h30, 32'(m_status));
            read_check("rnd_int_en", 8'h34, 32'(m_en));
            c = 16'($urandom);
            bus_wr(8'h30, 32'(c), 4'hF); m_status = m_status & ~c;
        end
        bus_wr(8'h30, 32'hFFFF, 4'hF); m_status = '0;

        // Asynchronous reset in the middle of a command and FIFO traffic
        bus_wr(8'h34, 32'h0008, 4'hF);
        int_set = 16'h0008;
        tick(1);
        int_set = '0;
        tick(1);
        check("irq_before_reset", 32'(irq), 32'h1);
        bus_wr(8'h0C, 32'h0000_0500, 4'hF);
        for (int i = 0; i < 5; i++) begin
            rd_push = 1'b1; rd_data = $urandom;
            tick(1);
        end
        rd_push = 1'b0;
        for (int i = 0; i < 3; i++) bus_wr(8'h20, $urandom, 4'hF);
        read_check("caps_before_reset", 8'h40, CAPS_V);
        rd_push = 1'b1; rd_data = $urandom;
        #2;
        resetn = 1'b0;
        #1;
        check("mid_rst_issue", 32'(cmd_issue), 32'h0);
        check("mid_rst_irq", 32'(irq), 32'h0);
        check("mid_rst_rvalid", 32'(bus_rvalid), 32'h0);
        check("mid_rst_rdata", bus_rdata, 32'h0);
        check("mid_rst_rd_full", 32'(rd_full), 32'h0);
        check("mid_rst_wr_empty", 32'(wr_empty), 32'h1);
        check("mid_rst_wr_data", wr_data, 32'h0);
        check("mid_rst_cmd_arg", cmd_arg, 32'h0);
        check("mid_rst_cmd_word", 32'(cmd_word), 32'h0);
        rd_push = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        resetn = 1'b1;
        tick(1);
        read_check("present_post_reset", 8'h24, m_present());
        read_check("int_en_post_reset", 8'h34, 32'(m_en));
        read_check("int_st_post_reset", 8'h30, 32'(m_status));
        read_check("buf_post_reset", 8'h20, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
